// File: rtl/traffic_light_pkg.sv
// Shared encodings for the traffic light controller and its monitor:
// light values, error codes, monitor FSM states and lane step codes.
package traffic_light_pkg;

    localparam int unsigned LIGHT_W = 2;
    localparam int unsigned CODE_W  = 3;
    localparam int unsigned ROT_W   = 16;

    localparam logic [LIGHT_W-1:0] LIGHT_G = 2'b00;
    localparam logic [LIGHT_W-1:0] LIGHT_Y = 2'b01;
    localparam logic [LIGHT_W-1:0] LIGHT_R = 2'b10;
    localparam logic [LIGHT_W-1:0] LIGHT_X = 2'b11;

    localparam logic [CODE_W-1:0] ERR_NONE     = 3'd0;
    localparam logic [CODE_W-1:0] ERR_ENC      = 3'd1;
    localparam logic [CODE_W-1:0] ERR_CONFLICT = 3'd2;
    localparam logic [CODE_W-1:0] ERR_TRANS    = 3'd3;
    localparam logic [CODE_W-1:0] ERR_YEL      = 3'd4;
    localparam logic [CODE_W-1:0] ERR_WDOG     = 3'd5;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_ERR   = 2'd2;

    // Legal light changes seen by a lane checker this cycle
    localparam logic [1:0] STEP_NONE = 2'd0;
    localparam logic [1:0] STEP_GY   = 2'd1;
    localparam logic [1:0] STEP_YR   = 2'd2;
    localparam logic [1:0] STEP_RG   = 2'd3;

    // Progress of lane A through a G->Y->R->G rotation
    localparam logic [1:0] ROT_IDLE = 2'd0;
    localparam logic [1:0] ROT_YEL  = 2'd1;
    localparam logic [1:0] ROT_RED  = 2'd2;

endpackage

// File: rtl/traffic_light_lane_chk.sv
// Per-lane checker: encoding, transition legality, yellow dwell and green
// watchdog, comparing each sample with the previous one.
module traffic_light_lane_chk
    import traffic_light_pkg::*;
#(
    parameter int unsigned P_YEL_CYC = 5,
    parameter int unsigned P_WDOG    = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LIGHT_W-1:0] light,
    input  logic               mode,
    output logic [CODE_W-1:0]  code_c,
    output logic [1:0]         step_c
);

    localparam int unsigned YEL_W = 9;
    localparam int unsigned GRN_W = 17;
    localparam logic [YEL_W-1:0] YEL_REQ = YEL_W'(P_YEL_CYC);
    localparam logic [YEL_W-1:0] YEL_SAT = YEL_W'(P_YEL_CYC + 1);
    localparam logic [GRN_W-1:0] GRN_SAT = GRN_W'(P_WDOG + 1);

    logic [LIGHT_W-1:0] prev;
    logic [YEL_W-1:0]   yel_cnt, yel_cnt_n;
    logic [GRN_W-1:0]   grn_cnt, grn_cnt_n;

    // Saturating dwell counters; parade mode keeps the green count at zero
    always_comb begin
        yel_cnt_n = '0;
        grn_cnt_n = '0;
        if (light == LIGHT_Y)
            yel_cnt_n = (yel_cnt == YEL_SAT) ? YEL_SAT : yel_cnt + YEL_W'(1);
        if (light == LIGHT_G && !mode)
            grn_cnt_n = (grn_cnt == GRN_SAT) ? GRN_SAT : grn_cnt + GRN_W'(1);
    end

    always_comb begin
        code_c = ERR_NONE;
        step_c = STEP_NONE;
        if (light == LIGHT_X) begin
            code_c = ERR_ENC;
        end else if (light != prev) begin
            if (prev == LIGHT_G && light == LIGHT_Y) begin
                step_c = STEP_GY;
            end else if (prev == LIGHT_Y && light == LIGHT_R) begin
                step_c = STEP_YR;
                if (yel_cnt != YEL_REQ)
                    code_c = ERR_YEL;
            end else if (prev == LIGHT_R && light == LIGHT_G) begin
                step_c = STEP_RG;
            end else begin
                code_c = ERR_TRANS;
            end
        end else if (yel_cnt_n == YEL_SAT && yel_cnt != YEL_SAT) begin
            code_c = ERR_YEL;
        end else if (grn_cnt_n == GRN_SAT && grn_cnt != GRN_SAT) begin
            code_c = ERR_WDOG;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= LIGHT_R;
            yel_cnt <= '0;
            grn_cnt <= '0;
        end else begin
            prev    <= light;
            yel_cnt <= yel_cnt_n;
            grn_cnt <= grn_cnt_n;
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light monitor: lane checks, conflict check, error priority,
// sticky error FSM and lane A rotation counter.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int unsigned P_YEL_CYC = 5,
    parameter int unsigned P_WDOG    = 100
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [LIGHT_W-1:0] i_LA,
    input  logic [LIGHT_W-1:0] i_LB,
    input  logic               i_M,
    input  logic               i_clr,
    output logic               o_err,
    output logic [CODE_W-1:0]  o_err_code,
    output logic               o_err_lane,
    output logic               o_rot_pulse,
    output logic [ROT_W-1:0]   o_rot_cnt
);

    logic [1:0]        state, state_n;
    logic [CODE_W-1:0] raw_code_a, raw_code_b, code_a, code_b;
    logic [1:0]        raw_step_a, step_a, raw_step_b;
    logic              check, conflict;
    logic [CODE_W-1:0] det_code, err_code_n;
    logic              det_lane, err_lane_n;
    logic [1:0]        rot_stage, rot_stage_n;
    logic              rot_pulse_n;
    logic [ROT_W-1:0]  rot_cnt_n;
    logic              unused_step_b;

    traffic_light_lane_chk #(.P_YEL_CYC(P_YEL_CYC), .P_WDOG(P_WDOG)) u_lane_a (
        .clk    (i_clk),
        .rst    (i_rst),
        .light  (i_LA),
        .mode   (i_M),
        .code_c (raw_code_a),
        .step_c (raw_step_a)
    );

    traffic_light_lane_chk #(.P_YEL_CYC(P_YEL_CYC), .P_WDOG(P_WDOG)) u_lane_b (
        .clk    (i_clk),
        .rst    (i_rst),
        .light  (i_LB),
        .mode   (i_M),
        .code_c (raw_code_b),
        .step_c (raw_step_b)
    );

    assign unused_step_b = ^raw_step_b;

    // The first sample after reset only primes the previous-sample registers
    assign check    = (state != ST_INIT);
    assign code_a   = check ? raw_code_a : ERR_NONE;
    assign code_b   = check ? raw_code_b : ERR_NONE;
    assign step_a   = check ? raw_step_a : STEP_NONE;
    assign conflict = check && (i_LA != LIGHT_R) && (i_LB != LIGHT_R);

    // Lowest code wins; at equal codes lane A (and the conflict) beat lane B
    always_comb begin
        det_code = ERR_NONE;
        det_lane = 1'b0;
        for (int c = 5; c >= 1; c--) begin
            if (code_b == 3'(c)) begin
                det_code = 3'(c);
                det_lane = 1'b1;
            end
            if (code_a == 3'(c) || (c == 2 && conflict)) begin
                det_code = 3'(c);
                det_lane = 1'b0;
            end
        end
    end

    always_comb begin
        state_n    = state;
        err_code_n = o_err_code;
        err_lane_n = o_err_lane;
        case (state)
            ST_INIT: state_n = ST_TRACK;
            ST_TRACK: begin
                if (det_code != ERR_NONE) begin
                    state_n    = ST_ERR;
                    err_code_n = det_code;
                    err_lane_n = det_lane;
                end
            end
            ST_ERR: begin
                if (i_clr) begin
                    if (det_code != ERR_NONE) begin
                        err_code_n = det_code;
                        err_lane_n = det_lane;
                    end else begin
                        state_n    = ST_TRACK;
                        err_code_n = ERR_NONE;
                        err_lane_n = 1'b0;
                    end
                end
            end
            default: state_n = ST_INIT;
        endcase
    end

    // Illegal encodings or transitions on A abandon a rotation in progress
    always_comb begin
        rot_stage_n = rot_stage;
        rot_pulse_n = 1'b0;
        rot_cnt_n   = o_rot_cnt;
        if (code_a == ERR_ENC || code_a == ERR_TRANS) begin
            rot_stage_n = ROT_IDLE;
        end else begin
            case (step_a)
                STEP_GY: rot_stage_n = ROT_YEL;
                STEP_YR: rot_stage_n = (rot_stage == ROT_YEL) ? ROT_RED : ROT_IDLE;
                STEP_RG: begin
                    if (rot_stage == ROT_RED) begin
                        rot_pulse_n = 1'b1;
                        rot_cnt_n   = o_rot_cnt + ROT_W'(1);
                    end
                    rot_stage_n = ROT_IDLE;
                end
                default: rot_stage_n = rot_stage;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_INIT;
            o_err       <= 1'b0;
            o_err_code  <= ERR_NONE;
            o_err_lane  <= 1'b0;
            rot_stage   <= ROT_IDLE;
            o_rot_pulse <= 1'b0;
            o_rot_cnt   <= '0;
        end else begin
            state       <= state_n;
            o_err       <= (state_n == ST_ERR);
            o_err_code  <= err_code_n;
            o_err_lane  <= err_lane_n;
            rot_stage   <= rot_stage_n;
            o_rot_pulse <= rot_pulse_n;
            o_rot_cnt   <= rot_cnt_n;
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: vector table, directed corner sequences and
// random traffic checked against a history-based reference model.
module tb_traffic_light_monitor;

    localparam int P_YEL = 5;
    localparam int P_WD  = 100;
    localparam int MAXH  = 2048;
    localparam logic [1:0] G = 2'b00, Y = 2'b01, R = 2'b10, X = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  la = R, lb = R;
    logic        m = 1'b0, clr = 1'b0;
    logic        err, lane, pulse;
    logic [2:0]  code;
    logic [15:0] cnt;

    always #5 clk = ~clk;

    traffic_light_monitor #(.P_YEL_CYC(P_YEL), .P_WDOG(P_WD)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_LA        (la),
        .i_LB        (lb),
        .i_M         (m),
        .i_clr       (clr),
        .o_err       (err),
        .o_err_code  (code),
        .o_err_lane  (lane),
        .o_rot_pulse (pulse),
        .o_rot_cnt   (cnt)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int any_err = 0;

    // Reference model: full sample history since reset plus the sticky flag
    logic [1:0]  ha [MAXH];
    logic [1:0]  hb [MAXH];
    logic        hm [MAXH];
    int          idx = 0;
    logic        mo_err = 1'b0, mo_lane = 1'b0, mo_pulse = 1'b0;
    logic [2:0]  mo_code = 3'd0;
    logic [15:0] mo_cnt = 16'd0;

    function automatic logic [1:0] hv(input int l, input int i);
        return (l == 0) ? ha[i] : hb[i];
    endfunction

    function automatic int yrun(input int l, input int i);
        int n = 0;
        int j = i;
        while (j >= 0 && n < P_YEL + 2 && hv(l, j) == Y) begin
            n++;
            j--;
        end
        return n;
    endfunction

    function automatic int grun(input int l, input int i);
        int n = 0;
        int j = i;
        while (j >= 0 && n < P_WD + 2 && hv(l, j) == G && !hm[j]) begin
            n++;
            j--;
        end
        return n;
    endfunction

    function automatic int lane_code(input int l, input int i);
        logic [1:0] c = hv(l, i);
        logic [1:0] p = hv(l, i - 1);
        if (c == X) return 1;
        if (c != p) begin
            if (p == G && c == Y) return 0;
            if (p == Y && c == R) return (yrun(l, i - 1) != P_YEL) ? 4 : 0;
            if (p == R && c == G) return 0;
            return 3;
        end
        if (c == Y && yrun(l, i) == P_YEL + 1) return 4;
        if (c == G && grun(l, i) == P_WD + 1) return 5;
        return 0;
    endfunction

    // A rotation completes when the run sequence of A ends in G,Y,R,G
    function automatic bit rotation(input int i);
        int j = i - 1;
        if (ha[i] != G || ha[j] != R) return 1'b0;
        while (j >= 0 && ha[j] == R) j--;
        if (j < 0 || ha[j] != Y) return 1'b0;
        while (j >= 0 && ha[j] == Y) j--;
        return (j >= 0 && ha[j] == G);
    endfunction

    task automatic model_step(input logic [1:0] a, input logic [1:0] b,
                              input logic mm, input logic cl);
        int ca, cb, best, bl;
        ha[idx] = a;
        hb[idx] = b;
        hm[idx] = mm;
        mo_pulse = 1'b0;
        if (idx > 0) begin
            ca = lane_code(0, idx);
            cb = lane_code(1, idx);
            best = ca;
            bl = 0;
            if (a != R && b != R && (best == 0 || best > 2)) best = 2;
            if (cb != 0 && (best == 0 || cb < best)) begin
                best = cb;
                bl = 1;
            end
            if (!mo_err) begin
                if (best != 0) begin
                    mo_err = 1'b1;
                    mo_code = 3'(best);
                    mo_lane = 1'(bl);
                end
            end else if (cl) begin
                if (best != 0) begin
                    mo_code = 3'(best);
                    mo_lane = 1'(bl);
                end else begin
                    mo_err = 1'b0;
                    mo_code = 3'd0;
                    mo_lane = 1'b0;
                end
            end
            if (rotation(idx)) begin
                mo_pulse = 1'b1;
                mo_cnt = mo_cnt + 16'd1;
            end
        end
        idx++;
    endtask

    task automatic expect_eq(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic check_model();
        checks++;
        if ({err, code, lane, pulse, cnt} != {mo_err, mo_code, mo_lane, mo_pulse, mo_cnt}) begin
            errors++;
            $display("FAIL model at %0t: got err=%0d code=%0d lane=%0d pulse=%0d cnt=%0d, expected err=%0d code=%0d lane=%0d pulse=%0d cnt=%0d",
                     $time, err, code, lane, pulse, cnt, mo_err, mo_code, mo_lane, mo_pulse, mo_cnt);
        end
    endtask

    task automatic cyc(input logic [1:0] a, input logic [1:0] b,
                       input logic mm, input logic cl);
        @(negedge clk);
        la = a;
        lb = b;
        m = mm;
        clr = cl;
        @(posedge clk);
        model_step(a, b, mm, cl);
        #1;
        check_model();
        if (pulse) pulses++;
        if (err) any_err++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        expect_eq("reset_err", int'(err), 0);
        expect_eq("reset_code", int'(code), 0);
        expect_eq("reset_lane", int'(lane), 0);
        expect_eq("reset_pulse", int'(pulse), 0);
        expect_eq("reset_cnt", int'(cnt), 0);
        idx = 0;
        mo_err = 1'b0;
        mo_code = 3'd0;
        mo_lane = 1'b0;
        mo_pulse = 1'b0;
        mo_cnt = 16'd0;
        @(posedge clk);
        #1 rst = 1'b0;
        pulses = 0;
        any_err = 0;
    endtask

    function automatic logic [1:0] nxt(input logic [1:0] c);
        case (c)
            G: return Y;
            Y: return R;
            default: return G;
        endcase
    endfunction

    typedef struct {
        logic [1:0] a, b;
        logic       mm, cl;
        logic       e;
        logic [2:0] c;
        logic       l, p;
    } vec_t;

    initial begin
        vec_t tbl [10];
        logic [1:0] ra, rb;
        logic rm, rc;
        int r;

        tbl[0] = '{G, R, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[1] = '{G, Y, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[2] = '{G, R, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[3] = '{Y, R, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[4] = '{R, R, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[5] = '{R, R, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[6] = '{G, G, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1};
        tbl[7] = '{G, G, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[8] = '{G, R, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0};
        tbl[9] = '{G, R, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};

        #1 rst = 1'b1;
        #1;
        expect_eq("por_err", int'(err), 0);
        expect_eq("por_code", int'(code), 0);
        expect_eq("por_cnt", int'(cnt), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Conflict, frozen first code, clear, error-beats-clear
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].a, tbl[i].b, tbl[i].mm, tbl[i].cl);
            expect_eq($sformatf("vec%0d", i), int'({err, code, lane, pulse}),
                      int'({tbl[i].e, tbl[i].c, tbl[i].l, tbl[i].p}));
        end

        // Legal rotation of A while B runs its own green phase
        do_reset();
        repeat (10) cyc(G, R, 1'b0, 1'b0);
        repeat (5)  cyc(Y, R, 1'b0, 1'b0);
        cyc(R, R, 1'b0, 1'b0);
        repeat (3)  cyc(R, G, 1'b0, 1'b0);
        repeat (5)  cyc(R, Y, 1'b0, 1'b0);
        cyc(R, R, 1'b0, 1'b0);
        cyc(G, R, 1'b0, 1'b0);
        expect_eq("rot_pulse", int'(pulse), 1);
        expect_eq("rot_pulses", pulses, 1);
        expect_eq("rot_cnt", int'(cnt), 1);
        expect_eq("rot_no_err", any_err, 0);

        // Reset in the middle of a yellow phase; first sample is unchecked
        repeat (2) cyc(Y, R, 1'b0, 1'b0);
        do_reset();
        cyc(Y, R, 1'b0, 1'b0);
        cyc(Y, R, 1'b0, 1'b0);
        expect_eq("post_rst_yel_err", int'(err), 0);

        // Short yellow on A
        do_reset();
        repeat (3) cyc(G, R, 1'b0, 1'b0);
        repeat (3) cyc(Y, R, 1'b0, 1'b0);
        cyc(R, R, 1'b0, 1'b0);
        expect_eq("short_yel_code", int'(code), 4);
        expect_eq("short_yel_lane", int'(lane), 0);

        // B green straight to red
        do_reset();
        cyc(R, G, 1'b0, 1'b0);
        cyc(R, R, 1'b0, 1'b0);
        expect_eq("b_gr_code", int'(code), 3);
        expect_eq("b_gr_lane", int'(lane), 1);

        // Watchdog trips on the 101st green sample, suppressed in parade mode
        do_reset();
        repeat (100) cyc(G, R, 1'b0, 1'b0);
        expect_eq("wdog_100_err", int'(err), 0);
        cyc(G, R, 1'b0, 1'b0);
        expect_eq("wdog_101_err", int'(err), 1);
        expect_eq("wdog_101_code", int'(code), 5);
        do_reset();
        repeat (120) cyc(G, R, 1'b1, 1'b0);
        expect_eq("parade_err", any_err, 0);

        // Illegal B encoding outranks an A transition error
        do_reset();
        cyc(G, R, 1'b0, 1'b0);
        cyc(R, X, 1'b0, 1'b0);
        expect_eq("enc_code", int'(code), 1);
        expect_eq("enc_lane", int'(lane), 1);

        // Reset while in ERR
        expect_eq("pre_rst_err", int'(err), 1);
        do_reset();
        cyc(Y, R, 1'b0, 1'b0);
        expect_eq("first_sample_unchecked", int'(err), 0);

        // Random traffic against the reference model
        do_reset();
        ra = R;
        rb = R;
        rm = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (idx >= 1200 || $urandom_range(999) == 0) do_reset();
            r = int'($urandom_range(99));
            if (r < 12) ra = nxt(ra);
            else if (r < 15) ra = 2'($urandom_range(3));
            r = int'($urandom_range(99));
            if (r < 12) rb = nxt(rb);
            else if (r < 15) rb = 2'($urandom_range(3));
            if ($urandom_range(49) == 0) rm = ~rm;
            rc = ($urandom_range(99) < 15);
            cyc(ra, rb, rm, rc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have parameter P_YEL_CYC, default 5: required yellow dwell in cycles, legal range 1..255.
REQ-002 SHALL have parameter P_WDOG, default 100: maximum green dwell in cycles, legal range 1..65535.
REQ-003 SHALL have ports:
  i_clk  input  1  sole clock, rising edge.
  i_rst  input  1  asynchronous reset, active-high.
  i_LA  input  2  street A light (00 green, 01 yellow, 10 red, 11 illegal).
  i_LB  input  2  street B light, same encoding.
  i_M  input  1  parade mode; 1 suppresses the green watchdog.
  i_clr  input  1  synchronous clear of the sticky error.
  o_err  output  1  sticky error flag.
  o_err_code  output  3  code of the first error latched.
  o_err_lane  output  1  lane of the first error (0 = A, 1 = B; 0 for code 2).
  o_rot_pulse  output  1  one-cycle pulse when A completes G->Y->R->G.
  o_rot_cnt  output  16  count of completed A rotations.

Function
REQ-004 SHALL be the consumer of the light outputs: sample i_LA, i_LB and i_M on every rising edge and compare each sample against the previous sample, held in registers.
REQ-005 SHALL use error codes: 0 none, 1 illegal encoding, 2 conflict (neither light red), 3 illegal transition, 4 yellow dwell violation, 5 green watchdog.
REQ-006 SHALL allow only these transitions per lane: hold, G->Y, Y->R, R->G; every other change is code 3.
REQ-007 SHALL count consecutive yellow cycles per lane with a counter that saturates at P_YEL_CYC+1.
REQ-008 SHALL flag code 4 on Y->R if the yellow count is not equal to P_YEL_CYC.
REQ-009 SHALL flag code 4 as soon as the yellow count reaches P_YEL_CYC+1 while the lane is still yellow.
REQ-010 SHALL count consecutive green cycles per lane with a counter that saturates at P_WDOG+1.
REQ-011 SHALL flag code 5 when the green count reaches P_WDOG+1 while i_M=0.
REQ-012 SHALL hold the green counter at 0 in any cycle where i_M=1.
REQ-013 SHALL run a monitor FSM with states INIT, TRACK, ERR:
  INIT: first sample after reset; no checks run; previous-sample registers load; go to TRACK.
  TRACK: any detected error -> ERR, latching code and lane.
  ERR: o_err=1; code and lane frozen (first error wins); i_clr=1 -> TRACK.
REQ-014 SHALL register all outputs so that an error is visible one cycle after the offending sample.
REQ-015 SHALL resolve errors detected in the same cycle by priority: lowest code first, then lane A before lane B.
REQ-016 SHALL give a new error priority over i_clr when both occur in the same cycle: stay in ERR and latch the new code.
REQ-017 SHALL continue updating dwell counters and rotation tracking while in ERR.
REQ-018 SHALL pulse o_rot_pulse and increment o_rot_cnt when A goes R->G after it has previously gone G->Y->R with no intervening illegal transition on A.
REQ-019 SHALL let o_rot_cnt wrap from 16'hFFFF to 0 without flagging an error.
REQ-020 SHALL compare an illegal-encoding sample only for code 1 and store it without transition checks; the next sample is checked against it as a hold or code 3.

Reset
REQ-021 SHALL, on i_rst assertion at any time including mid-dwell or in ERR, asynchronously force state INIT, clear all counters, set previous lights to red (10), and drive o_err=0, o_err_code=0, o_err_lane=0, o_rot_pulse=0, o_rot_cnt=0.
REQ-022 SHALL take its first sample on the first rising edge after i_rst deasserts.

Structure
REQ-023 SHALL place the light encoding constants, error codes and FSM state encoding in a shared package traffic_light_pkg, which is also used by the controller.
REQ-024 SHALL implement the per-lane encoding, transition, yellow-dwell and green-watchdog checks in a sub-module traffic_light_lane_chk, instantiated twice (A and B).
REQ-025 SHALL limit the top level to the conflict check, priority resolution, FSM and rotation counter.

Verification
REQ-026 SHALL cover legal rotation: A G(10 cycles)->Y(5)->R with B R->G->Y(5)->R, then A G -> o_rot_pulse once, o_rot_cnt=1, o_err=0.
REQ-027 SHALL cover conflict: LA=00 and LB=01 for one cycle -> o_err=1 and o_err_code=2 the next cycle, and the code stays 2 after later errors.
REQ-028 SHALL cover short yellow: A yellow 3 cycles then red (P_YEL_CYC=5) -> code 4, lane 0; and B green->red directly -> code 3, lane 1 on a fresh run.
REQ-029 SHALL cover the watchdog: A green for 101 cycles with i_M=0 -> code 5 at cycle 101; the same with i_M=1 -> no error.
REQ-030 SHALL cover simultaneous events: LB=11 together with an A transition error -> code 1; error and i_clr in the same cycle -> o_err stays 1 with the new code.
REQ-031 SHALL cover reset mid-operation: i_rst pulsed during ERR and mid-yellow -> all outputs 0 immediately and the first post-reset sample is not checked.
